// File: rtl/fnd_scan_if.sv
// fnd_scan_if: time word / mode select in, digit anodes and segments out,
// for the 4-digit common-anode 7-segment display on the Basys3 board.
//   master : the side that supplies the time word and watches the display
//   slave  : fnd_scan_controller
// These are free-running level signals with no valid/ready handshake. The
// controller samples fnd_time/sw_mode only at the start of each display frame.
interface fnd_scan_if;
    logic [23:0] fnd_time;   // {hour[23:19], min[18:13], sec[12:7], msec[6:0]}
    logic        sw_mode;    // 0 = sec:msec, 1 = hour:min
    logic [3:0]  fnd_com;    // active-low anodes, bit 0 = rightmost digit
    logic [7:0]  fnd_data;   // active-low {dp,g,f,e,d,c,b,a}

    modport master (
        output fnd_time,
        output sw_mode,
        input  fnd_com,
        input  fnd_data
    );

    modport slave (
        input  fnd_time,
        input  sw_mode,
        output fnd_com,
        output fnd_data
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: scans a 4-digit common-anode 7-segment display.
// At each frame start it takes a snapshot of the 24-bit time word and the
// mode select. It shows one pair of fields as four BCD digits, advancing one
// digit every TICK_DIV clocks. The centre dot blinks at 1 Hz (lit while
// msec < 50).
// Optional build macro: FND_LZ_BLANK_EN blanks digit 3 when its value is 0.
module fnd_scan_controller #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    fnd_scan_if.slave     bus
);
    localparam int TICK_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

`ifdef FND_LZ_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("fnd_scan_controller: CLK_FREQ_HZ/SCAN_HZ must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic [1:0]       r_dig;
    logic [23:0]      r_snap_time;
    logic             r_snap_mode;
    logic             r_load;
    logic [3:0]       r_fnd_com;
    logic [7:0]       r_fnd_data;

    logic [6:0]       w_lo;
    logic [6:0]       w_hi;
    logic [3:0]       w_d0;
    logic [3:0]       w_d1;
    logic [3:0]       w_d2;
    logic [3:0]       w_d3;
    logic [7:0]       w_seg;
    logic [3:0]       w_com;

    // Digit value to active-low {g..a}. Anything above 9 is shown as "-".
    function automatic logic [7:0] f_seg(input logic [3:0] v);
        logic [7:0] seg;
        case (v)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hBF;
        endcase
        return seg;
    endfunction

    assign w_tick = (r_div_cnt == DIV_LAST);

    // Scan-rate divider: wraps after TICK_DIV cycles; the last count is the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Digit pointer. The 3->0 wrap starts a frame and captures the snapshot,
    // so all four digits of a frame come from the same time word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig       <= 2'd3;
            r_snap_time <= '0;
            r_snap_mode <= 1'b0;
        end else if (w_tick) begin
            r_dig <= r_dig + 2'd1;
            if (r_dig == 2'd3) begin
                r_snap_time <= bus.fnd_time;
                r_snap_mode <= bus.sw_mode;
            end
        end
    end

    // Segment and anode pattern for the digit the pointer now selects.
    // Fields are widened to 7 bits before the divide, so out-of-range values
    // such as msec=127 give d1=12 and show as "-".
    always_comb begin
        w_lo  = '0;
        w_hi  = '0;
        w_seg = 8'hFF;
        w_com = 4'b1111;

        if (r_snap_mode) begin
            w_lo = {1'b0, r_snap_time[18:13]};
            w_hi = {2'b00, r_snap_time[23:19]};
        end else begin
            w_lo = r_snap_time[6:0];
            w_hi = {1'b0, r_snap_time[12:7]};
        end

        w_d0 = 4'(w_lo % 7'd10);
        w_d1 = 4'(w_lo / 7'd10);
        w_d2 = 4'(w_hi % 7'd10);
        w_d3 = 4'(w_hi / 7'd10);

        case (r_dig)
            2'd0: begin
                w_com = 4'b1110;
                w_seg = f_seg(w_d0);
            end
            2'd1: begin
                w_com = 4'b1101;
                w_seg = f_seg(w_d1);
            end
            2'd2: begin
                w_com = 4'b1011;
                w_seg = f_seg(w_d2);
                // Centre dot: lit for the first half of each second.
                if (r_snap_time[6:0] < 7'd50) begin
                    w_seg[7] = 1'b0;
                end
            end
            default: begin
                w_com = 4'b0111;
                w_seg = (LZ_BLANK && (w_d3 == 4'd0)) ? 8'hFF : f_seg(w_d3);
            end
        endcase
    end

    // Output register. It loads one cycle after each tick, so anodes and
    // segments change together. Before the first frame it holds the blank
    // reset pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load     <= 1'b0;
            r_fnd_com  <= 4'b1111;
            r_fnd_data <= 8'hFF;
        end else begin
            r_load <= w_tick;
            if (r_load) begin
                r_fnd_com  <= w_com;
                r_fnd_data <= w_seg;
            end
        end
    end

    assign bus.fnd_com  = r_fnd_com;
    assign bus.fnd_data = r_fnd_data;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: display controller run at TICK_DIV=4.
// A timeline model counts clock edges since reset release, works out which
// digit and which frame snapshot each edge shows, and computes the pattern
// from the field arithmetic. Directed frames pin known patterns, then random
// time words follow, then an asynchronous reset in the middle of a digit.
module tb_fnd_scan_controller;
    localparam int CLK_FREQ_HZ = 4000;
    localparam int SCAN_HZ     = 1000;
    localparam int TICK_DIV    = CLK_FREQ_HZ / SCAN_HZ;

`ifdef FND_LZ_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    localparam logic [23:0] T1 = {5'd12, 6'd34, 6'd56, 7'd78};
    localparam logic [23:0] T3 = {5'd0, 6'd0, 6'd5, 7'd30};
    localparam logic [23:0] T4 = {5'd0, 6'd0, 6'd0, 7'd127};

    logic clk;
    logic rst_n;
    fnd_scan_if u_if ();

    fnd_scan_controller #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .SCAN_HZ     (SCAN_HZ)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // ---------------- reference model ----------------
    int          m_e;        // clock edges since reset release
    logic [23:0] m_snap_t;
    logic        m_snap_m;
    logic [3:0]  exp_com;
    logic [7:0]  exp_data;

    function automatic logic [11:0] model_out(input int digit, input logic [23:0] t, input logic m);
        int lo, hi, v;
        logic [7:0] d;
        logic [3:0] c;
        lo = m ? int'(t[18:13]) : int'(t[6:0]);
        hi = m ? int'(t[23:19]) : int'(t[12:7]);
        case (digit)
            0:       v = lo % 10;
            1:       v = lo / 10;
            2:       v = hi % 10;
            default: v = hi / 10;
        endcase
        d = (v <= 9) ? seg_tab[v] : 8'hBF;
        if (digit == 3 && v == 0 && LZ_BLANK) d = 8'hFF;
        if (digit == 2 && int'(t[6:0]) < 50) d = d & 8'h7F;
        c = ~(4'b0001 << digit);
        return {c, d};
    endfunction

    initial begin
        m_e      = 0;
        m_snap_t = '0;
        m_snap_m = 1'b0;
        exp_com  = 4'b1111;
        exp_data = 8'hFF;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_e      = 0;
                m_snap_t = '0;
                m_snap_m = 1'b0;
                exp_com  = 4'b1111;
                exp_data = 8'hFF;
            end else begin
                m_e = m_e + 1;
                // Edge m_e shows the digit of the frame that is on screen,
                // which is still the previous snapshot at a frame boundary.
                if (m_e > TICK_DIV) begin
                    {exp_com, exp_data} = model_out(((m_e - TICK_DIV - 1) / TICK_DIV) % 4,
                                                    m_snap_t, m_snap_m);
                end
                if (m_e >= TICK_DIV && ((m_e - TICK_DIV) % (4 * TICK_DIV)) == 0) begin
                    m_snap_t = u_if.fnd_time;
                    m_snap_m = u_if.sw_mode;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [3:0] c, input logic [7:0] d);
        n_tests++;
        if (u_if.fnd_com !== c || u_if.fnd_data !== d) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got com=%b data=%h, expected com=%b data=%h",
                     name, m_e, u_if.fnd_com, u_if.fnd_data, c, d);
        end
    endtask

    // Compare the DUT with the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model", exp_com, exp_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_e(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            if (m_e == n) hit = 1'b1;
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_e: edge %0d never reached (now %0d)", n, m_e);
        end
    endtask

    task automatic drive_random();
        logic [23:0] t;
        if ($urandom_range(0, 3) == 0) begin
            t = 24'($urandom);
        end else begin
            t = {5'($urandom_range(0, 23)), 6'($urandom_range(0, 59)),
                 6'($urandom_range(0, 59)), 7'($urandom_range(0, 99))};
        end
        u_if.fnd_time = t;
        u_if.sw_mode  = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        u_if.fnd_time = T1;
        u_if.sw_mode  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold", 4'b1111, 8'hFF);
        rst_n = 1'b1;

        // Frame 1: T1, sec:msec.
        wait_e(4);  check("idle_before_first", 4'b1111, 8'hFF);
        wait_e(5);  check("f1_d0", 4'b1110, 8'h80);
        wait_e(9);  check("f1_d1", 4'b1101, 8'hF8);
        wait_e(10); u_if.sw_mode = 1'b1;
        wait_e(13); check("f1_d2_no_tear", 4'b1011, 8'h82);
        wait_e(17); check("f1_d3_no_tear", 4'b0111, 8'h92);
        // Frame 2: T1, hour:min.
        wait_e(21); check("f2_d0", 4'b1110, 8'h99);
        wait_e(25); check("f2_d1", 4'b1101, 8'hB0);
        wait_e(26); u_if.fnd_time = T3; u_if.sw_mode = 1'b0;
        wait_e(29); check("f2_d2_no_tear", 4'b1011, 8'hA4);
        wait_e(33); check("f2_d3_no_tear", 4'b0111, 8'hF9);
        // Frame 3: sec=5, msec=30 (dot lit, leading zero).
        wait_e(37); check("f3_d0", 4'b1110, 8'hC0);
        wait_e(45); check("f3_d2_dot", 4'b1011, 8'h12);
        wait_e(46); u_if.fnd_time = T4;
        wait_e(49); check("f3_d3_lz", 4'b0111, LZ_BLANK ? 8'hFF : 8'hC0);
        // Frame 4: msec=127 (out of range).
        wait_e(53); check("f4_d0", 4'b1110, 8'hF8);
        wait_e(57); check("f4_d1_dash", 4'b1101, 8'hBF);
        wait_e(61); check("f4_d2_no_dot", 4'b1011, 8'hC0);

        // Random time words at random moments.
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) drive_random();
        end

        // Asynchronous reset in the middle of a digit, then restart.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b1111, 8'hFF);
        repeat (2) @(negedge clk);
        u_if.fnd_time = T1;
        u_if.sw_mode  = 1'b0;
        rst_n         = 1'b1;
        wait_e(4);  check("restart_idle", 4'b1111, 8'hFF);
        wait_e(5);  check("restart_d0", 4'b1110, 8'h80);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) drive_random();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
